// File: rtl/twiddle_seq.sv
// Twiddle-address sequencer for a shared-butterfly radix-2 DIF FFT.
// Walks stage/butterfly per frame, issues twiddle index k, and delays a tag to align with W.
module twiddle_seq #(
   parameter int ADDR_WIDTH = 11,
   parameter int W_LAT      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            cfg_log_n,
   input  logic                  bf_ready,
   output logic [ADDR_WIDTH+1:0] k,
   output logic                  k_valid,
   output logic                  w_valid,
   output logic [3:0]            w_stage,
   output logic [ADDR_WIDTH:0]   w_bfly,
   output logic                  w_last,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  cfg_err,
   output logic [1:0]            dbg_state
);

   localparam int K_W = ADDR_WIDTH + 2;
   localparam int B_W = ADDR_WIDTH + 1;
   localparam logic [3:0] MAX_LOG = 4'(K_W);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   typedef struct packed {
      logic           valid;
      logic [3:0]     stage;
      logic [B_W-1:0] bfly;
      logic           last;
      logic           frame_last;
   } tag_t;

   state_t         state_q, state_d;
   logic [3:0]     log_n_q, log_n_d;
   logic [3:0]     s_q, s_d;
   logic [B_W-1:0] j_q, j_d;
   logic [K_W-1:0] k_q, k_d;
   tag_t           iss_q, iss_d;
   tag_t           dl_q [W_LAT];
   tag_t           dl_d [W_LAT];
   logic           cfg_err_q, cfg_err_d;

   logic [K_W-1:0] half_n, span_mask, p, e, k_new;
   logic [B_W-1:0] j_max;
   logic [3:0]     span_sh;
   logic           last_bfly, last_stage, cfg_ok, done_now;

   // Handshake: an issue happens on a rising edge in RUN with bf_ready high; k_valid
   // marks it one cycle later. There is no backpressure on the w side: w_valid is a
   // one-cycle event that the butterfly must consume immediately.
   always_comb begin
      half_n     = K_W'(1) << (log_n_q - 4'd1);
      j_max      = B_W'(half_n - K_W'(1));
      span_sh    = log_n_q - 4'd1 - s_q;
      span_mask  = (K_W'(1) << span_sh) - K_W'(1);
      p          = K_W'(j_q) & span_mask;
      e          = p << s_q;
      k_new      = e << (MAX_LOG - log_n_q);
      last_bfly  = (j_q == j_max);
      last_stage = (s_q == log_n_q - 4'd1);
      cfg_ok     = (cfg_log_n >= 4'd2) && (cfg_log_n <= MAX_LOG);
      done_now   = dl_q[W_LAT-1].valid && dl_q[W_LAT-1].frame_last;
   end

   always_comb begin
      state_d   = state_q;
      log_n_d   = log_n_q;
      s_d       = s_q;
      j_d       = j_q;
      k_d       = k_q;
      iss_d     = '0;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_d = RUN;
                  log_n_d = cfg_log_n;
                  s_d     = 4'd0;
                  j_d     = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (bf_ready) begin
               k_d              = k_new;
               iss_d.valid      = 1'b1;
               iss_d.stage      = s_q;
               iss_d.bfly       = j_q;
               iss_d.last       = last_bfly;
               iss_d.frame_last = last_bfly && last_stage;
               if (last_bfly) begin
                  j_d = '0;
                  s_d = s_q + 4'd1;
                  if (last_stage) state_d = DRAIN;
               end else begin
                  j_d = j_q + B_W'(1);
               end
            end
         end
         DRAIN: begin
            if (done_now) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The generator is free-running, so the tag pipe shifts every cycle.
   always_comb begin
      dl_d[0] = iss_q;
      for (int i = 1; i < W_LAT; i++) dl_d[i] = dl_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         log_n_q   <= '0;
         s_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         iss_q     <= '0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < W_LAT; i++) dl_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         log_n_q   <= log_n_d;
         s_q       <= s_d;
         j_q       <= j_d;
         k_q       <= k_d;
         iss_q     <= iss_d;
         cfg_err_q <= cfg_err_d;
         for (int i = 0; i < W_LAT; i++) dl_q[i] <= dl_d[i];
      end
   end

   assign k          = k_q;
   assign k_valid    = iss_q.valid;
   assign w_valid    = dl_q[W_LAT-1].valid;
   assign w_stage    = dl_q[W_LAT-1].stage;
   assign w_bfly     = dl_q[W_LAT-1].bfly;
   assign w_last     = dl_q[W_LAT-1].last;
   assign frame_done = done_now;
   assign busy       = (state_q != IDLE);
   assign cfg_err    = cfg_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq: fixed vectors with hand-computed k/tag/timing values.
module tb_twiddle_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  cfg_log_n = 4'd0;
   logic        bf_ready = 1'b0;
   logic [12:0] k;
   logic        k_valid, w_valid, w_last, frame_done, busy, cfg_err;
   logic [3:0]  w_stage;
   logic [11:0] w_bfly;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int tbl3 [12] = '{0, 1024, 2048, 3072, 0, 2048, 0, 2048, 0, 0, 0, 0};
   int tbl2k [7] = '{0, 0, 2048, 2048, 0, 0, 0};

   twiddle_seq #(.ADDR_WIDTH(11), .W_LAT(2)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_log_n(cfg_log_n), .bf_ready(bf_ready),
      .k(k), .k_valid(k_valid), .w_valid(w_valid), .w_stage(w_stage), .w_bfly(w_bfly),
      .w_last(w_last), .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_k"}, 32'(k), 32'd0);
      chk({tag, "_kv"}, 32'(k_valid), 32'd0);
      chk({tag, "_wv"}, 32'(w_valid), 32'd0);
      chk({tag, "_wtag"}, 32'({w_stage, w_bfly, w_last}), 32'd0);
      chk({tag, "_fd"}, 32'(frame_done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(cfg_err), 32'd0);
   endtask

   // L=3 frame with bf_ready held high; optionally pokes an extra start mid-frame.
   task automatic run_l3(input bit poke);
      int it;
      start = 1'b1; cfg_log_n = 4'd3; bf_ready = 1'b1;
      step();
      start = 1'b0;
      chk("l3_busy_rise", 32'(busy), 32'd1);
      chk("l3_kv_at_start", 32'(k_valid), 32'd0);
      for (int c = 1; c <= 15; c++) begin
         if (poke && c == 5) begin start = 1'b1; cfg_log_n = 4'd2; end
         else start = 1'b0;
         step();
         chk("l3_kv", 32'(k_valid), 32'(c <= 12));
         if (c <= 12) chk("l3_k", 32'(k), 32'(tbl3[c-1]));
         chk("l3_wv", 32'(w_valid), 32'(c >= 3 && c <= 14));
         if (c >= 3 && c <= 14) begin
            it = c - 3;
            chk("l3_wstage", 32'(w_stage), 32'(it / 4));
            chk("l3_wbfly", 32'(w_bfly), 32'(it % 4));
            chk("l3_wlast", 32'(w_last), 32'(it % 4 == 3));
         end
         chk("l3_fd", 32'(frame_done), 32'(c == 14));
         chk("l3_busy", 32'(busy), 32'(c <= 14));
      end
      start = 1'b0;
      cfg_log_n = 4'd0;
   endtask

   initial begin
      int cnt, bad0, bad12, msb, kv_bad, fd_at, seen;

      // Reset
      rst = 1'b1;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      // Basic L=3 frame, with an ignored start while busy
      run_l3(1'b1);

      // Illegal sizes
      start = 1'b1; cfg_log_n = 4'd1;
      step();
      start = 1'b0;
      chk("err1_pulse", 32'(cfg_err), 32'd1);
      chk("err1_busy", 32'(busy), 32'd0);
      step();
      chk("err1_clear", 32'(cfg_err), 32'd0);
      chk("err1_kv", 32'(k_valid), 32'd0);
      start = 1'b1; cfg_log_n = 4'd14;
      step();
      start = 1'b0;
      chk("err14_pulse", 32'(cfg_err), 32'd1);
      chk("err14_busy", 32'(busy), 32'd0);
      step();
      chk("err14_clear", 32'(cfg_err), 32'd0);
      chk("err14_kv", 32'(k_valid), 32'd0);
      chk("err14_busy2", 32'(busy), 32'd0);

      // L=2 with bf_ready toggling 1,0,1,0,...
      start = 1'b1; cfg_log_n = 4'd2; bf_ready = 1'b0;
      step();
      start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         bf_ready = c[0];
         step();
         chk("l2_kv", 32'(k_valid), 32'(c[0] == 1'b1 && c <= 7));
         chk("l2_k", 32'(k), (c <= 7) ? 32'(tbl2k[c-1]) : 32'd0);
         chk("l2_wv", 32'(w_valid), 32'(c[0] == 1'b1 && c >= 3 && c <= 9));
         chk("l2_wlast", 32'(w_last), 32'(c == 5 || c == 9));
         chk("l2_fd", 32'(frame_done), 32'(c == 9));
         chk("l2_busy", 32'(busy), 32'(c <= 9));
      end
      bf_ready = 1'b1;

      // Back-to-back frame starting as soon as busy reads low
      run_l3(1'b0);
      run_l3(1'b0);

      // Reset mid-frame
      start = 1'b1; cfg_log_n = 4'd4; bf_ready = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("mid_kv_live", 32'(k_valid), 32'd1);
      rst = 1'b1;
      step();
      chk_all_zero("mid_rst");
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (frame_done || w_valid || k_valid || busy) seen++;
      end
      chk("mid_quiet", 32'(seen), 32'd0);

      // Fresh frame after abort
      run_l3(1'b0);

      // L=13 full frame
      start = 1'b1; cfg_log_n = 4'd13; bf_ready = 1'b1;
      step();
      start = 1'b0;
      cnt = 0; bad0 = 0; bad12 = 0; msb = 0; kv_bad = 0; fd_at = -1;
      for (int c = 1; c <= 53251; c++) begin
         step();
         if (k_valid !== (c <= 53248)) kv_bad++;
         if (k_valid) begin
            if (c - 1 < 4096 && k !== 13'(c - 1)) bad0++;
            if (c - 1 >= 49152 && k !== 13'd0) bad12++;
            if (k[12]) msb++;
            cnt++;
         end
         if (frame_done) fd_at = c;
      end
      chk("l13_issues", 32'(cnt), 32'd53248);
      chk("l13_kv_pattern", 32'(kv_bad), 32'd0);
      chk("l13_stage0", 32'(bad0), 32'd0);
      chk("l13_stage12", 32'(bad12), 32'd0);
      chk("l13_msb", 32'(msb), 32'd0);
      chk("l13_fd_cycle", 32'(fd_at), 32'd53250);
      chk("l13_busy_end", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
